// File: rtl/hex_scan_driver_pkg.sv
// Shared display constants for the hex scan driver and the board top.
// Holds default geometry, digit-select polarity and index-width helper.
package hex_scan_driver_pkg;

    localparam int DEFAULT_DIGITS   = 8;
    localparam int DEFAULT_SCAN_DIV = 50000;

    // Common-anode digits are selected by pulling their anode driver low.
    localparam logic DIGIT_ON  = 1'b0;
    localparam logic DIGIT_OFF = 1'b1;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/hex_scan_driver_scan_prescaler.sv
// Free-running divider: tick is high for one clk cycle out of every DIV.
// Reusable by any display or LED block that needs a slow strobe.
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed seven-segment scanner; commits new words only at frame wrap.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_driver
    import hex_scan_driver_pkg::*;
#(
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    output logic [3:0]            hex,
    output logic [DIGITS-1:0]     digit_an,
    output logic                  frame_start,
    output logic [4*DIGITS-1:0]   shown
);

    localparam int IDX_W = idx_width(DIGITS);

    logic                tick;
    logic                boundary;

    logic [IDX_W-1:0]    idx_q,         idx_d;
    logic [4*DIGITS-1:0] pending_q,     pending_d;
    logic                dirty_q,       dirty_d;
    logic [4*DIGITS-1:0] shown_q,       shown_d;
    logic [3:0]          hex_q,         hex_d;
    logic [DIGITS-1:0]   digit_an_q,    digit_an_d;
    logic                frame_start_q, frame_start_d;

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign boundary = tick && (idx_q == IDX_W'(DIGITS - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        idx_d         = idx_q;
        pending_d     = pending_q;
        dirty_d       = dirty_q;
        shown_d       = shown_q;
        hex_d         = hex_q;
        digit_an_d    = digit_an_q;
        frame_start_d = 1'b0;

        if (tick) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        // Commit reads the old pending, so a write in the boundary cycle waits one frame.
        if (boundary && dirty_q) begin
            shown_d = pending_q;
            dirty_d = 1'b0;
        end
        if (wr_en) begin
            pending_d = wr_data;
            dirty_d   = 1'b1;
        end

        if (tick) begin
            hex_d             = shown_d[4*idx_d +: 4];
            digit_an_d        = {DIGITS{DIGIT_OFF}};
            digit_an_d[idx_d] = DIGIT_ON;
            frame_start_d     = (idx_d == '0);
`ifdef HEX_SCAN_LZB_EN
            if ((idx_d != '0) && ((shown_d >> (4*idx_d)) == '0)) begin
                hex_d      = 4'h0;
                digit_an_d = {DIGITS{DIGIT_OFF}};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            pending_q     <= '0;
            dirty_q       <= 1'b0;
            shown_q       <= '0;
            hex_q         <= 4'h0;
            digit_an_q    <= {{(DIGITS-1){DIGIT_OFF}}, DIGIT_ON};
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            dirty_q       <= dirty_d;
            shown_q       <= shown_d;
            hex_q         <= hex_d;
            digit_an_q    <= digit_an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hex         = hex_q;
    assign digit_an    = digit_an_q;
    assign frame_start = frame_start_q;
    assign shown       = shown_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with DIGITS=4, SCAN_DIV=2.
// Expected scan position is derived from the cycle count since reset release.
module tb_hex_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 2;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  hex;
    logic [3:0]  digit_an;
    logic        frame_start;
    logic [15:0] shown;

    int checks;
    int errors;
    int k;

    hex_scan_driver #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .hex         (hex),
        .digit_an    (digit_an),
        .frame_start (frame_start),
        .shown       (shown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Expected outputs after k edges since reset release, given the displayed word.
    task automatic check_scan(input logic [15:0] exp_shown);
        int         idx;
        logic [3:0] exp_an;
        logic [3:0] exp_hex;
        idx     = (k / SCAN_DIV) % DIGITS;
        exp_an  = ~(4'b0001 << idx);
        exp_hex = exp_shown[4*idx +: 4];
`ifdef HEX_SCAN_LZB_EN
        if (idx > 0 && (exp_shown >> (4*idx)) == 16'h0) begin
            exp_an  = 4'b1111;
            exp_hex = 4'h0;
        end
`endif
        check("shown", 32'(shown), 32'(exp_shown));
        check("digit_an", 32'(digit_an), 32'(exp_an));
        check("hex", 32'(hex), 32'(exp_hex));
        check("frame_start", 32'(frame_start),
              32'((k % (DIGITS*SCAN_DIV) == 0) && (k > 0)));
    endtask

    task automatic run_until(input int last, input logic [15:0] exp_shown);
        while (k < last) begin
            step();
            check_scan(exp_shown);
        end
    endtask

    task automatic write_cycle(input logic [15:0] d, input logic [15:0] exp_shown);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        check_scan(exp_shown);
    endtask

    task automatic check_reset_values();
        check("rst_hex", 32'(hex), 32'h0);
        check("rst_digit_an", 32'(digit_an), 32'hE);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_shown", 32'(shown), 32'h0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        k       = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 16'h0;

        repeat (3) step();
        check_reset_values();
        rst = 1'b0;
        k   = 0;

        // Blank scan: anodes walk 1110,1101,1011,0111 and frame_start at each wrap.
        run_until(10, 16'h0000);

        // Mid-frame write becomes visible only at the next boundary (k=16).
        write_cycle(16'h1234, 16'h0000);
        run_until(15, 16'h0000);
        run_until(25, 16'h1234);

        // Back-to-back writes: the last one wins.
        write_cycle(16'hAAAA, 16'h1234);
        write_cycle(16'h5555, 16'h1234);
        run_until(31, 16'h1234);
        run_until(41, 16'h5555);

        // Write in the boundary cycle with 1111 pending: 1111 first, then BEEF.
        write_cycle(16'h1111, 16'h5555);
        run_until(47, 16'h5555);
        write_cycle(16'hBEEF, 16'h1111);
        run_until(55, 16'h1111);
        run_until(65, 16'hBEEF);

        // Leading zeros: 0040 then 0000.
        write_cycle(16'h0040, 16'hBEEF);
        run_until(71, 16'hBEEF);
        run_until(81, 16'h0040);
        write_cycle(16'h0000, 16'h0040);
        run_until(87, 16'h0040);
        run_until(89, 16'h0000);
        write_cycle(16'hABCD, 16'h0000);
        run_until(95, 16'h0000);
        run_until(97, 16'hABCD);

        // Reset during digit 2 with a pending write; the pending value must never appear.
        write_cycle(16'h9999, 16'hABCD);
        run_until(100, 16'hABCD);
        rst = 1'b1;
        step();
        check_reset_values();
        rst = 1'b0;
        k   = 0;
        run_until(20, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
